medac_tuner: RTL and testbench
==============================

MEDAC_TUNER -- requirements
Module: medac_tuner

Interface
REQ-001 Parameter CNT_W, default 32: width of the cumulative counter inputs and window result outputs.
REQ-002 Parameter WIN_CYC, default 1024: window length in clk cycles.
REQ-003 Parameter SETTLE_CYC, default 64: clk cycles held idle after any delay_sel change.
REQ-004 Parameter LO_WINS, default 4: consecutive quiet windows required before a step down.
REQ-005 Ports, in order:
- clk  in  1  the single clock; all logic on its rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  level enable; low forces IDLE.
- error_origin_cnt  in  CNT_W  cumulative error count from medac, synchronous to clk, free-running and wrapping.
- cycle_cnt  in  CNT_W  cumulative cycle count from medac, synchronous to clk, free-running and wrapping.
- hi_th  in  CNT_W  window error count above which delay is increased.
- lo_th  in  CNT_W  window error count below which a window counts as quiet.
- delay_sel  out  3  delay code driven to medac delay_sel_d1.
- win_err  out  CNT_W  error delta of the last completed window.
- win_cyc  out  CNT_W  cycle delta of the last completed window.
- win_done  out  1  one-cycle pulse when win_err and win_cyc update.
- at_max  out  1  high while delay_sel==7 and the last window exceeded hi_th.

Function
REQ-006 FSM states: IDLE, ARM, RUN, EVAL, SETTLE.
REQ-007 IDLE -> ARM when start==1; any state -> IDLE on the cycle after start is sampled 0, with delay_sel held.
REQ-008 ARM: snapshot both input counters into base registers, clear the window timer, go to RUN (1 cycle).
REQ-009 RUN: increment the timer each cycle; on timer==WIN_CYC-1, go to EVAL.
REQ-010 EVAL (1 cycle): win_err = error_origin_cnt - err_base, and win_cyc = cycle_cnt - cyc_base, both modulo 2^CNT_W so counter wrap yields the correct delta; win_done=1 for that cycle.
REQ-011 EVAL decision, evaluated on the delta being registered:
- delta > hi_th: delay_sel+1, saturating at 7; clear the quiet counter.
- delta < lo_th: increment the quiet counter; if it reaches LO_WINS, delay_sel-1 saturating at 0, and clear the quiet counter.
- otherwise: clear the quiet counter.
REQ-012 If hi_th <= lo_th, hi_th takes priority; a delta satisfying both SHALL step up.
REQ-013 EVAL -> SETTLE if delay_sel changed, else -> ARM; a saturated no-op counts as unchanged.
REQ-014 SETTLE: count SETTLE_CYC cycles, then -> ARM; windows spanning a delay change SHALL never be evaluated.
REQ-015 delay_sel changes only on the EVAL-exit edge, at most one step per window.
REQ-016 at_max updates only in EVAL.
REQ-017 Latency: win_done asserts exactly WIN_CYC+1 cycles after ARM.

Reset
REQ-018 While rst_n==0 at a clk edge: state=IDLE, delay_sel=0, win_err=0, win_cyc=0, win_done=0, at_max=0, quiet counter=0, timer=0, base registers=0.
REQ-019 Reset asserted mid-window discards the window; no win_done is produced.

Structure
REQ-020 A shared package medac_pkg holds the FSM state enum, DELAY_MAX=7, and the default WIN_CYC, SETTLE_CYC, and LO_WINS constants.
REQ-021 One sub-module, medac_win_delta, holds the base registers and the modular subtraction for one counter; it is instantiated twice.

Verification
REQ-022 WIN_CYC=16, hi_th=4; error count rises by 5 per window -> win_err=5, and delay_sel steps 0->1->...->7, one step per window+SETTLE, then at_max=1.
REQ-023 lo_th=2, LO_WINS=4, delay_sel preset 3 via prior ramp; zero errors -> delay_sel=2 after exactly the 4th quiet window, not before.
REQ-024 error_origin_cnt base=0xFFFF_FFFE with 5 errors in the window -> win_err=5 (wrap), win_cyc=WIN_CYC.
REQ-025 start dropped mid-RUN, then raised -> no win_done from the aborted window; the next win_done occurs WIN_CYC+1 cycles after re-ARM.
REQ-026 hi_th=lo_th=3 with delta=2 -> quiet; with delta=4 -> step up; rst_n low mid-window -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/medac_pkg.sv
// -----------------------------------------------------------------------------
// medac_pkg
// Shared definitions for the medac delay tuner: FSM state encoding, the
// largest legal delay code, default timing constants and a small helper used
// to size counters.
// -----------------------------------------------------------------------------
package medac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_RUN    = 3'd2,
        ST_EVAL   = 3'd3,
        ST_SETTLE = 3'd4
    } state_t;

    localparam int DELAY_MAX          = 7;
    localparam int DEFAULT_WIN_CYC    = 1024;
    localparam int DEFAULT_SETTLE_CYC = 64;
    localparam int DEFAULT_LO_WINS    = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/medac_win_delta.sv
// -----------------------------------------------------------------------------
// medac_win_delta
// Window delta for one free-running, wrapping cumulative counter. The counter
// value is snapshotted at window start and the difference is registered at
// window end. Unsigned CNT_W-bit subtraction is modulo 2^CNT_W, so a counter
// that wraps inside the window still yields the correct delta.
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset, clears base and delta
//   snap   : load cnt_in into the base register
//   cap    : register cnt_in - base into delta
//   cnt_in : cumulative counter input
//   delta  : last captured window delta
// -----------------------------------------------------------------------------
module medac_win_delta
    import medac_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             snap,
    input  logic             cap,
    input  logic [CNT_W-1:0] cnt_in,
    output logic [CNT_W-1:0] delta
);

    logic [CNT_W-1:0] base_reg;
    logic [CNT_W-1:0] delta_reg;
    logic [CNT_W-1:0] delta_next;

    assign delta_next = cnt_in - base_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_reg  <= '0;
            delta_reg <= '0;
        end else begin
            if (snap) begin
                base_reg <= cnt_in;
            end
            if (cap) begin
                delta_reg <= delta_next;
            end
        end
    end

    assign delta = delta_reg;

endmodule

// File: rtl/medac_tuner.sv
// -----------------------------------------------------------------------------
// medac_tuner
// Closed-loop tuner for the medac delay code. Error and cycle deltas are
// measured over fixed windows of WIN_CYC cycles; a noisy window steps the
// delay up, LO_WINS consecutive quiet windows step it down. After any change
// the tuner idles SETTLE_CYC cycles so no window ever straddles a change.
//
// Ports:
//   clk              : clock, rising edge
//   rst_n            : synchronous active-low reset
//   start            : level enable; low returns the FSM to IDLE
//   error_origin_cnt : cumulative error count (wrapping)
//   cycle_cnt        : cumulative cycle count (wrapping)
//   hi_th            : window error count above which delay steps up
//   lo_th            : window error count below which a window is quiet
//   delay_sel        : delay code to medac
//   win_err          : error delta of the last completed window
//   win_cyc          : cycle delta of the last completed window
//   win_done         : one-cycle pulse while win_err/win_cyc are fresh
//   at_max           : delay is at its ceiling and still too noisy
// -----------------------------------------------------------------------------
module medac_tuner
    import medac_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int WIN_CYC    = DEFAULT_WIN_CYC,
    parameter int SETTLE_CYC = DEFAULT_SETTLE_CYC,
    parameter int LO_WINS    = DEFAULT_LO_WINS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] error_origin_cnt,
    input  logic [CNT_W-1:0] cycle_cnt,
    input  logic [CNT_W-1:0] hi_th,
    input  logic [CNT_W-1:0] lo_th,
    output logic [2:0]       delay_sel,
    output logic [CNT_W-1:0] win_err,
    output logic [CNT_W-1:0] win_cyc,
    output logic             win_done,
    output logic             at_max
);

    // One timer serves both the measurement window and the settle period.
    localparam int TMR_W = $clog2(max_int(WIN_CYC, SETTLE_CYC) + 1);
    localparam int QW    = $clog2(LO_WINS + 1);

    localparam logic [TMR_W-1:0] WIN_LAST    = TMR_W'(WIN_CYC - 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [QW-1:0]    QUIET_FULL  = QW'(LO_WINS);
    localparam logic [2:0]       DSEL_MAX    = 3'(DELAY_MAX);

    state_t           state_reg;
    state_t           state_next;
    logic [TMR_W-1:0] timer_reg;
    logic [QW-1:0]    quiet_reg;
    logic [QW-1:0]    quiet_next;
    logic [QW-1:0]    quiet_inc;
    logic [2:0]       delay_reg;
    logic [2:0]       delay_next;
    logic             at_max_reg;
    logic             win_done_reg;

    // Decision terms, valid while in EVAL (win_err holds the fresh delta).
    logic step_up;
    logic quiet;
    logic quiet_hit;
    logic delay_change;

    // FSM-driven controls
    logic snap_en;
    logic cap_en;
    logic eval_en;
    logic timer_inc;

    // ---------------------------------------------------------------- deltas
    medac_win_delta #(.CNT_W(CNT_W)) u_err_delta (
        .clk    (clk),
        .rst_n  (rst_n),
        .snap   (snap_en),
        .cap    (cap_en),
        .cnt_in (error_origin_cnt),
        .delta  (win_err)
    );

    medac_win_delta #(.CNT_W(CNT_W)) u_cyc_delta (
        .clk    (clk),
        .rst_n  (rst_n),
        .snap   (snap_en),
        .cap    (cap_en),
        .cnt_in (cycle_cnt),
        .delta  (win_cyc)
    );

    // -------------------------------------------------------------- decision
    // Step-up is checked first so that with hi_th <= lo_th a delta meeting
    // both conditions still raises the delay.
    assign quiet_inc = quiet_reg + QW'(1);

    always_comb begin
        step_up    = (win_err > hi_th);
        quiet      = !step_up && (win_err < lo_th);
        quiet_hit  = quiet && (quiet_inc == QUIET_FULL);
        delay_next = delay_reg;
        quiet_next = '0;
        if (step_up) begin
            if (delay_reg != DSEL_MAX) begin
                delay_next = delay_reg + 3'd1;
            end
        end else if (quiet) begin
            if (quiet_hit) begin
                if (delay_reg != 3'd0) begin
                    delay_next = delay_reg - 3'd1;
                end
            end else begin
                quiet_next = quiet_inc;
            end
        end
        // A saturated step leaves delay_next equal, so it is not a change.
        delay_change = (delay_next != delay_reg);
    end

    // ---------------------------------------------------------- state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -------------------------------------------------------------- next state
    always_comb begin
        state_next = state_reg;
        if (!start) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:   state_next = ST_ARM;
                ST_ARM:    state_next = ST_RUN;
                ST_RUN:    if (timer_reg == WIN_LAST) state_next = ST_EVAL;
                ST_EVAL:   state_next = delay_change ? ST_SETTLE : ST_ARM;
                ST_SETTLE: if (timer_reg == SETTLE_LAST) state_next = ST_ARM;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------ FSM outputs
    // The deltas are captured on the edge into EVAL, so win_err/win_cyc are
    // stable throughout EVAL and the decision reads the registered values.
    // Dropping start on the last RUN cycle sends the FSM to IDLE and the
    // capture is skipped, so an aborted window never reports.
    always_comb begin
        snap_en   = (state_reg == ST_ARM);
        cap_en    = (state_reg == ST_RUN) && (state_next == ST_EVAL);
        eval_en   = (state_reg == ST_EVAL) && start;
        timer_inc = (state_reg == ST_RUN) || (state_reg == ST_SETTLE);
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer_reg    <= '0;
            quiet_reg    <= '0;
            delay_reg    <= 3'd0;
            at_max_reg   <= 1'b0;
            win_done_reg <= 1'b0;
        end else begin
            win_done_reg <= cap_en;

            // Leaving RUN/SETTLE always lands in EVAL, ARM or IDLE, where the
            // timer is cleared ready for the next RUN or SETTLE pass.
            if (timer_inc && (state_next == state_reg)) begin
                timer_reg <= timer_reg + TMR_W'(1);
            end else begin
                timer_reg <= '0;
            end

            // Delay and quiet count move only on a normal EVAL exit; an EVAL
            // aborted by start going low holds the delay as it was.
            if (eval_en) begin
                delay_reg  <= delay_next;
                quiet_reg  <= quiet_next;
                at_max_reg <= step_up && (delay_next == DSEL_MAX);
            end
        end
    end

    assign delay_sel = delay_reg;
    assign at_max    = at_max_reg;
    assign win_done  = win_done_reg;

endmodule

// File: tb/tb_medac_tuner.sv
// -----------------------------------------------------------------------------
// tb_medac_tuner
// Directed bench for medac_tuner with WIN_CYC=16, SETTLE_CYC=4, LO_WINS=4.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// Window timing seen from the falling edge of an EVAL cycle (or of the cycle
// in which start is raised): the next win_done appears 18 falling edges later,
// or 22 when the previous window changed delay_sel (4 settle cycles).
// Errors are injected at falling edges 8..12 of a window, which lies inside
// the measured span in both cases.
// -----------------------------------------------------------------------------
module tb_medac_tuner;

    localparam int CNT_W      = 32;
    localparam int WIN_CYC    = 16;
    localparam int SETTLE_CYC = 4;
    localparam int LO_WINS    = 4;
    localparam int LAT_PLAIN  = WIN_CYC + 2;
    localparam int LAT_SETTLE = WIN_CYC + 2 + SETTLE_CYC;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] error_origin_cnt = '0;
    logic [CNT_W-1:0] cycle_cnt = 32'hFFFF_FF00;
    logic [CNT_W-1:0] hi_th = '0;
    logic [CNT_W-1:0] lo_th = '0;
    logic [2:0]       delay_sel;
    logic [CNT_W-1:0] win_err;
    logic [CNT_W-1:0] win_cyc;
    logic             win_done;
    logic             at_max;

    int compared   = 0;
    int mismatched = 0;

    medac_tuner #(
        .CNT_W      (CNT_W),
        .WIN_CYC    (WIN_CYC),
        .SETTLE_CYC (SETTLE_CYC),
        .LO_WINS    (LO_WINS)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .error_origin_cnt (error_origin_cnt),
        .cycle_cnt        (cycle_cnt),
        .hi_th            (hi_th),
        .lo_th            (lo_th),
        .delay_sel        (delay_sel),
        .win_err          (win_err),
        .win_cyc          (win_cyc),
        .win_done         (win_done),
        .at_max           (at_max)
    );

    always #5 clk = ~clk;

    // Free-running cycle counter; starts near the top so it wraps mid-run.
    always @(negedge clk) cycle_cnt = cycle_cnt + 1;

    // Stimulus helpers (no checking inside).
    task automatic do_reset();
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Runs one window from the current falling edge, injecting nerr errors,
    // and returns the number of falling edges until win_done (-1 on timeout).
    task automatic run_window(input int nerr, output int lat);
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i >= 8 && i < 8 + nerr) error_origin_cnt = error_origin_cnt + 1;
            if (win_done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        do_reset();
        compared++; if (delay_sel !== 3'd0) begin mismatched++; $display("FAIL reset_delay_sel: got %0d want 0", delay_sel); end
        compared++; if (win_err !== '0) begin mismatched++; $display("FAIL reset_win_err: got %0d want 0", win_err); end
        compared++; if (win_cyc !== '0) begin mismatched++; $display("FAIL reset_win_cyc: got %0d want 0", win_cyc); end
        compared++; if (win_done !== 1'b0) begin mismatched++; $display("FAIL reset_win_done: got %0b want 0", win_done); end
        compared++; if (at_max !== 1'b0) begin mismatched++; $display("FAIL reset_at_max: got %0b want 0", at_max); end
        $display("reset: delay_sel=%0d win_err=%0d win_cyc=%0d at_max=%0b", delay_sel, win_err, win_cyc, at_max);
    endtask

    task automatic test_ramp();
        int lat;
        int exp_lat;
        int exp_dsel;
        logic exp_max;
        do_reset();
        hi_th = 4;
        lo_th = 0;
        start = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            run_window(5, lat);
            exp_lat  = (k == 1 || k == 9) ? LAT_PLAIN : LAT_SETTLE;
            exp_dsel = (k - 1 > 7) ? 7 : k - 1;
            exp_max  = (k >= 8);
            $display("ramp win %0d: lat=%0d win_err=%0d win_cyc=%0d delay_sel=%0d at_max=%0b", k, lat, win_err, win_cyc, delay_sel, at_max);
            compared++; if (lat != exp_lat) begin mismatched++; $display("FAIL ramp_latency[%0d]: got %0d want %0d", k, lat, exp_lat); end
            compared++; if (win_err !== 32'd5) begin mismatched++; $display("FAIL ramp_win_err[%0d]: got %0d want 5", k, win_err); end
            compared++; if (win_cyc !== 32'd16) begin mismatched++; $display("FAIL ramp_win_cyc[%0d]: got %0d want 16", k, win_cyc); end
            compared++; if (delay_sel !== 3'(exp_dsel)) begin mismatched++; $display("FAIL ramp_delay_sel[%0d]: got %0d want %0d", k, delay_sel, exp_dsel); end
            compared++; if (at_max !== exp_max) begin mismatched++; $display("FAIL ramp_at_max[%0d]: got %0b want %0b", k, at_max, exp_max); end
        end
        @(negedge clk);
        compared++; if (win_done !== 1'b0) begin mismatched++; $display("FAIL ramp_win_done_pulse: got %0b want 0", win_done); end
        compared++; if (at_max !== 1'b1) begin mismatched++; $display("FAIL ramp_at_max_final: got %0b want 1", at_max); end
        $display("ramp end: delay_sel=%0d at_max=%0b", delay_sel, at_max);
    endtask

    // Continues straight from test_ramp: outputs are non-zero going in.
    task automatic test_reset_mid();
        int seen;
        seen = 0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        compared++; if (delay_sel !== 3'd0) begin mismatched++; $display("FAIL midrst_delay_sel: got %0d want 0", delay_sel); end
        compared++; if (win_err !== '0) begin mismatched++; $display("FAIL midrst_win_err: got %0d want 0", win_err); end
        compared++; if (win_cyc !== '0) begin mismatched++; $display("FAIL midrst_win_cyc: got %0d want 0", win_cyc); end
        compared++; if (at_max !== 1'b0) begin mismatched++; $display("FAIL midrst_at_max: got %0b want 0", at_max); end
        for (int i = 0; i < 12; i++) begin
            if (i == 2) rst_n = 1'b1;
            if (win_done === 1'b1) seen++;
            @(negedge clk);
        end
        compared++; if (seen != 0) begin mismatched++; $display("FAIL midrst_no_win_done: got %0d pulses want 0", seen); end
        $display("mid-window reset: outputs cleared, win_done pulses=%0d", seen);
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_quiet();
        int lat;
        int exp_lat[5] = '{LAT_SETTLE, LAT_PLAIN, LAT_PLAIN, LAT_PLAIN, LAT_SETTLE};
        int exp_dsel[5] = '{3, 3, 3, 3, 2};
        do_reset();
        hi_th = 4;
        lo_th = 2;
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            run_window(5, lat);
            $display("quiet preset win %0d: lat=%0d delay_sel=%0d", k, lat, delay_sel);
            compared++; if (delay_sel !== 3'(k)) begin mismatched++; $display("FAIL quiet_preset_dsel[%0d]: got %0d want %0d", k, delay_sel, k); end
        end
        for (int q = 0; q < 5; q++) begin
            run_window(0, lat);
            $display("quiet win %0d: lat=%0d win_err=%0d delay_sel=%0d", q + 1, lat, win_err, delay_sel);
            compared++; if (lat != exp_lat[q]) begin mismatched++; $display("FAIL quiet_latency[%0d]: got %0d want %0d", q + 1, lat, exp_lat[q]); end
            compared++; if (win_err !== '0) begin mismatched++; $display("FAIL quiet_win_err[%0d]: got %0d want 0", q + 1, win_err); end
            compared++; if (delay_sel !== 3'(exp_dsel[q])) begin mismatched++; $display("FAIL quiet_delay_sel[%0d]: got %0d want %0d", q + 1, delay_sel, exp_dsel[q]); end
        end
        start = 1'b0;
    endtask

    task automatic test_wrap();
        int lat;
        do_reset();
        hi_th = 100;
        lo_th = 0;
        error_origin_cnt = 32'hFFFF_FFFE;
        start = 1'b1;
        run_window(5, lat);
        $display("wrap: lat=%0d win_err=%0d win_cyc=%0d delay_sel=%0d", lat, win_err, win_cyc, delay_sel);
        compared++; if (lat != LAT_PLAIN) begin mismatched++; $display("FAIL wrap_latency: got %0d want %0d", lat, LAT_PLAIN); end
        compared++; if (win_err !== 32'd5) begin mismatched++; $display("FAIL wrap_win_err: got %0d want 5", win_err); end
        compared++; if (win_cyc !== 32'd16) begin mismatched++; $display("FAIL wrap_win_cyc: got %0d want 16", win_cyc); end
        compared++; if (delay_sel !== 3'd0) begin mismatched++; $display("FAIL wrap_delay_sel: got %0d want 0", delay_sel); end
        start = 1'b0;
    endtask

    task automatic test_abort();
        int lat;
        int seen;
        seen = 0;
        do_reset();
        hi_th = 100;
        lo_th = 0;
        start = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 4 || i == 5) error_origin_cnt = error_origin_cnt + 1;
            if (win_done === 1'b1) seen++;
        end
        start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (win_done === 1'b1) seen++;
        end
        compared++; if (seen != 0) begin mismatched++; $display("FAIL abort_no_win_done: got %0d pulses want 0", seen); end
        start = 1'b1;
        run_window(3, lat);
        $display("abort then rearm: aborted pulses=%0d lat=%0d win_err=%0d win_cyc=%0d", seen, lat, win_err, win_cyc);
        compared++; if (lat != LAT_PLAIN) begin mismatched++; $display("FAIL abort_rearm_latency: got %0d want %0d", lat, LAT_PLAIN); end
        compared++; if (win_err !== 32'd3) begin mismatched++; $display("FAIL abort_win_err: got %0d want 3", win_err); end
        compared++; if (win_cyc !== 32'd16) begin mismatched++; $display("FAIL abort_win_cyc: got %0d want 16", win_cyc); end
        start = 1'b0;
    endtask

    task automatic test_equal_th();
        int lat;
        int nerr[7]     = '{2, 4, 2, 2, 2, 2, 2};
        int exp_lat[7]  = '{LAT_PLAIN, LAT_PLAIN, LAT_SETTLE, LAT_PLAIN, LAT_PLAIN, LAT_PLAIN, LAT_SETTLE};
        int exp_dsel[7] = '{0, 0, 1, 1, 1, 1, 0};
        do_reset();
        hi_th = 3;
        lo_th = 3;
        start = 1'b1;
        for (int k = 0; k < 7; k++) begin
            run_window(nerr[k], lat);
            $display("equal_th win %0d: nerr=%0d lat=%0d win_err=%0d delay_sel=%0d", k + 1, nerr[k], lat, win_err, delay_sel);
            compared++; if (lat != exp_lat[k]) begin mismatched++; $display("FAIL eqth_latency[%0d]: got %0d want %0d", k + 1, lat, exp_lat[k]); end
            compared++; if (win_err !== 32'(nerr[k])) begin mismatched++; $display("FAIL eqth_win_err[%0d]: got %0d want %0d", k + 1, win_err, nerr[k]); end
            compared++; if (delay_sel !== 3'(exp_dsel[k])) begin mismatched++; $display("FAIL eqth_delay_sel[%0d]: got %0d want %0d", k + 1, delay_sel, exp_dsel[k]); end
        end
        start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_reset_mid();
        test_quiet();
        test_wrap();
        test_abort();
        test_equal_th();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
